// File: rtl/fetch_unit.sv
// Instruction fetch initiator for the RV32 core.
// Presents fetch addresses to the instruction memory, which returns data one
// cycle later. The in-flight request is tracked so that its PC and misalignment
// flag line up with the returned word. A downstream stall replays the same
// address, and a redirect restarts fetch with no bubble. After a fetch fault
// has been delivered, fetch halts until the next redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_fetch_en,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_imem_pc,
   input  logic [31:0] i_imem_insn,
   input  logic        i_imem_exception,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_insn,
   output logic [31:0] o_pc,
   output logic        o_exception
);

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        resp_valid_q;
   logic [31:0] resp_pc_q;
   logic        resp_exc_q;

   logic        stall_s;
   logic        issue_s;
   logic [31:0] imem_pc_s;

   // Stall/issue decisions and the address presented to memory this cycle
   always_comb begin
      stall_s = resp_valid_q & ~i_ready;
      // Sequential issue needs fetch enabled; a redirect always issues
      issue_s = i_redirect | ((state_q == RUN) & i_fetch_en & ~stall_s);
      if (i_redirect) begin
         imem_pc_s = i_redirect_pc;
      end else if (stall_s) begin
         // Re-present the pending word so memory returns it again next cycle
         imem_pc_s = resp_pc_q;
      end else begin
         imem_pc_s = pc_q;
      end
   end

   // FSM, next-issue PC and the in-flight response registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         resp_valid_q <= 1'b0;
         resp_pc_q    <= RESET_PC;
         resp_exc_q   <= 1'b0;
      end else begin
         if (issue_s) begin
            resp_valid_q <= 1'b1;
            resp_pc_q    <= imem_pc_s;
            resp_exc_q   <= i_imem_exception;
            pc_q         <= imem_pc_s + 32'd4;
            // A misaligned issue is the last one until the next redirect
            state_q      <= i_imem_exception ? TRAP : RUN;
         end else begin
            if (!stall_s) begin
               // Response accepted (or none pending) and nothing new issued
               resp_valid_q <= 1'b0;
            end
            case (state_q)
               IDLE:    state_q <= i_fetch_en ? RUN : IDLE;
               RUN:     state_q <= (!i_fetch_en && !stall_s) ? IDLE : RUN;
               TRAP:    state_q <= TRAP;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Decode-facing outputs; a redirect squashes the response it overtakes
   always_comb begin
      o_imem_pc   = imem_pc_s;
      o_valid     = resp_valid_q & ~i_redirect;
      o_pc        = resp_pc_q;
      o_exception = resp_valid_q & ~i_redirect & resp_exc_q;
      if (resp_exc_q || !resp_valid_q) begin
         o_insn = NOP_INSN;
      end else begin
         o_insn = i_imem_insn;
      end
   end

endmodule
